// File: rtl/bakraid_pcm_rom_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bakraid_pcm_rom_ctrl
// Description : Sequences YMZ280B sample-ROM byte reads onto three 4 MB SDRAM
//               PCM bank slots. Keeps one bank request open until that bank
//               answers, returns the byte with a single-cycle valid pulse, and
//               provides a 1-entry last-byte cache plus a stall timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module bakraid_pcm_rom_ctrl #(
  parameter logic [15:0] TIMEOUT = 16'd4095
) (
  input  logic        CLK96,
  input  logic        RESET96,
  input  logic        YMZ_RD,
  input  logic [23:0] YMZ_ADDR,
  output logic [7:0]  YMZ_DOUT,
  output logic        YMZ_VALID,
  input  logic        CACHE_FLUSH,
  output logic        PCM_CS,
  output logic [21:0] PCM_ADDR,
  input  logic        PCM_OK,
  input  logic [7:0]  PCM_DOUT,
  output logic        PCM1_CS,
  output logic [21:0] PCM1_ADDR,
  input  logic        PCM1_OK,
  input  logic [7:0]  PCM1_DOUT,
  output logic        PCM2_CS,
  output logic [21:0] PCM2_ADDR,
  input  logic        PCM2_OK,
  input  logic [7:0]  PCM2_DOUT,
  output logic        BUSY,
  output logic        TMO_ERR
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Counter value of the last WAIT cycle before the fetch is abandoned
  localparam logic [15:0] LAST_COUNT = TIMEOUT - 16'd1;

  state_t      state, state_n;
  logic [2:0]  cs, cs_n;
  logic [21:0] addr0, addr0_n;
  logic [21:0] addr1, addr1_n;
  logic [21:0] addr2, addr2_n;
  logic [1:0]  bank, bank_n;
  logic [23:0] req_addr, req_addr_n;
  logic [15:0] count, count_n;
  logic [7:0]  dout, dout_n;
  logic        valid, valid_n;
  logic        tmo, tmo_n;
  logic        c_valid, c_valid_n;
  logic [23:0] c_tag, c_tag_n;
  logic [7:0]  c_data, c_data_n;
  logic        sel_ok;
  logic [7:0]  sel_dout;

  // Pick the handshake of the bank that owns the open request; others are ignored
  always_comb begin
    sel_ok   = 1'b0;
    sel_dout = 8'h00;
    case (bank)
      2'd0:    begin sel_ok = PCM_OK;  sel_dout = PCM_DOUT;  end
      2'd1:    begin sel_ok = PCM1_OK; sel_dout = PCM1_DOUT; end
      2'd2:    begin sel_ok = PCM2_OK; sel_dout = PCM2_DOUT; end
      default: begin sel_ok = 1'b0;    sel_dout = 8'h00;     end
    endcase
  end

  // Next-state and next-register values for the fetch sequencer
  always_comb begin
    state_n    = state;
    cs_n       = cs;
    addr0_n    = addr0;
    addr1_n    = addr1;
    addr2_n    = addr2;
    bank_n     = bank;
    req_addr_n = req_addr;
    count_n    = count;
    dout_n     = dout;
    valid_n    = 1'b0;
    tmo_n      = tmo;
    c_valid_n  = c_valid;
    c_tag_n    = c_tag;
    c_data_n   = c_data;

    case (state)
      ST_IDLE: begin
        if (YMZ_RD) begin
          req_addr_n = YMZ_ADDR;
          if (c_valid && (c_tag == YMZ_ADDR)) begin
            dout_n  = c_data;
            valid_n = 1'b1;
            state_n = ST_ACK;
          end else if (YMZ_ADDR[23:22] == 2'b11) begin
            // Beyond the three banks: answer zero without touching SDRAM
            dout_n  = 8'h00;
            valid_n = 1'b1;
            state_n = ST_ACK;
          end else begin
            bank_n  = YMZ_ADDR[23:22];
            count_n = 16'd0;
            state_n = ST_WAIT;
            case (YMZ_ADDR[23:22])
              2'd0:    begin cs_n = 3'b001; addr0_n = YMZ_ADDR[21:0]; end
              2'd1:    begin cs_n = 3'b010; addr1_n = YMZ_ADDR[21:0]; end
              2'd2:    begin cs_n = 3'b100; addr2_n = YMZ_ADDR[21:0]; end
              default: begin cs_n = 3'b000; end
            endcase
          end
        end
      end

      ST_WAIT: begin
        if (count != 16'hFFFF) begin
          count_n = count + 16'd1;
        end
        // An OK seen in the first WAIT cycle may belong to the previous address
        if ((count != 16'd0) && sel_ok) begin
          dout_n    = sel_dout;
          c_tag_n   = req_addr;
          c_data_n  = sel_dout;
          c_valid_n = 1'b1;
          cs_n      = 3'b000;
          valid_n   = YMZ_RD;
          state_n   = ST_ACK;
        end else if (count == LAST_COUNT) begin
          dout_n  = 8'h00;
          tmo_n   = 1'b1;
          cs_n    = 3'b000;
          valid_n = YMZ_RD;
          state_n = ST_ACK;
        end
      end

      ST_ACK: begin
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
        cs_n    = 3'b000;
      end
    endcase

    // A flush overrides any fill landing on the same edge
    if (CACHE_FLUSH) begin
      c_valid_n = 1'b0;
    end
  end

  // Register all sequencer state; reset abandons any fetch in flight
  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      state    <= ST_IDLE;
      cs       <= 3'b000;
      addr0    <= 22'd0;
      addr1    <= 22'd0;
      addr2    <= 22'd0;
      bank     <= 2'd0;
      req_addr <= 24'd0;
      count    <= 16'd0;
      dout     <= 8'h00;
      valid    <= 1'b0;
      tmo      <= 1'b0;
      c_valid  <= 1'b0;
      c_tag    <= 24'd0;
      c_data   <= 8'h00;
    end else begin
      state    <= state_n;
      cs       <= cs_n;
      addr0    <= addr0_n;
      addr1    <= addr1_n;
      addr2    <= addr2_n;
      bank     <= bank_n;
      req_addr <= req_addr_n;
      count    <= count_n;
      dout     <= dout_n;
      valid    <= valid_n;
      tmo      <= tmo_n;
      c_valid  <= c_valid_n;
      c_tag    <= c_tag_n;
      c_data   <= c_data_n;
    end
  end

  assign PCM_CS    = cs[0];
  assign PCM1_CS   = cs[1];
  assign PCM2_CS   = cs[2];
  assign PCM_ADDR  = addr0;
  assign PCM1_ADDR = addr1;
  assign PCM2_ADDR = addr2;
  assign YMZ_DOUT  = dout;
  assign YMZ_VALID = valid;
  assign TMO_ERR   = tmo;
  assign BUSY      = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bakraid_pcm_rom_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bakraid_pcm_rom_ctrl
// Description : Self-checking bench for bakraid_pcm_rom_ctrl. Each read is
//               predicted by a transaction-level model (ROM contents, cache
//               entry, sticky timeout flag) and compared with what the bench
//               observes on the bank and YMZ sides.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bakraid_pcm_rom_ctrl;

  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rd, flush;
  logic [23:0] addr;
  logic [7:0]  ydout;
  logic        yvalid, busy, tmo_err;
  logic        cs0, cs1, cs2;
  logic [21:0] a0, a1, a2;
  logic [2:0]  ok;
  logic [7:0]  d0, d1, d2;

  int checks = 0;
  int errors = 0;

  // Sample ROM: every bank byte is a fixed function of bank and offset
  function automatic logic [7:0] rom(input logic [1:0] b, input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ {b, 6'b000000} ^ 8'hB5;
  endfunction

  assign d0 = rom(2'd0, a0);
  assign d1 = rom(2'd1, a1);
  assign d2 = rom(2'd2, a2);

  bakraid_pcm_rom_ctrl #(.TIMEOUT(16'(TO))) dut (
    .CLK96(clk), .RESET96(rst), .YMZ_RD(rd), .YMZ_ADDR(addr),
    .YMZ_DOUT(ydout), .YMZ_VALID(yvalid), .CACHE_FLUSH(flush),
    .PCM_CS(cs0), .PCM_ADDR(a0), .PCM_OK(ok[0]), .PCM_DOUT(d0),
    .PCM1_CS(cs1), .PCM1_ADDR(a1), .PCM1_OK(ok[1]), .PCM1_DOUT(d1),
    .PCM2_CS(cs2), .PCM2_ADDR(a2), .PCM2_OK(ok[2]), .PCM2_DOUT(d2),
    .BUSY(busy), .TMO_ERR(tmo_err)
  );

  // Transaction-level model state
  bit          m_valid;
  logic [23:0] m_tag;
  logic [7:0]  m_data;
  bit          m_tmo;
  int          exp_cs [3];
  int          exp_vcount, exp_vcycle;
  logic [7:0]  exp_dout;

  // Observations of one read
  int          obs_cs [3];
  int          obs_vcount, obs_vcycle, obs_addr_err, obs_multi;
  logic [7:0]  obs_dout;
  logic        obs_busy;

  // Predict one read: CS cycles per bank, valid cycle, returned byte
  task automatic model_read(input logic [23:0] a, input int ok_at, input int abort_at, input int flush_at);
    int w;
    bit got;
    for (int b = 0; b < 3; b++) exp_cs[b] = 0;
    if (m_valid && m_tag == a) begin
      exp_vcount = 1; exp_vcycle = 1; exp_dout = m_data;
    end else if (a[23:22] == 2'b11) begin
      exp_vcount = 1; exp_vcycle = 1; exp_dout = 8'h00;
    end else begin
      got = (ok_at >= 2) && (ok_at <= TO);
      w = got ? ok_at : TO;
      exp_cs[a[23:22]] = w;
      exp_dout = got ? rom(a[23:22], a[21:0]) : 8'h00;
      if (got) begin
        m_valid = 1'b1; m_tag = a; m_data = exp_dout;
      end else begin
        m_tmo = 1'b1;
      end
      if (abort_at != 0 && abort_at <= w) begin
        exp_vcount = 0; exp_vcycle = 0;
      end else begin
        exp_vcount = 1; exp_vcycle = w + 1;
      end
    end
    if (flush_at != 0) m_valid = 1'b0;
  endtask

  // Drive one read and record what happens over a fixed window
  task automatic run_read(input logic [23:0] a, input int ok_at, input bit stale, input int abort_at, input int flush_at);
    int sel;
    sel = int'(a[23:22]);
    for (int b = 0; b < 3; b++) obs_cs[b] = 0;
    obs_vcount = 0; obs_vcycle = 0; obs_addr_err = 0; obs_multi = 0;
    @(negedge clk);
    rd = 1'b1; addr = a; flush = 1'b0;
    for (int b = 0; b < 3; b++) ok[b] = (b == sel) ? 1'b0 : 1'($urandom_range(0, 1));
    for (int c = 1; c <= TO + 6; c++) begin
      @(negedge clk);
      if (cs0) obs_cs[0]++;
      if (cs1) obs_cs[1]++;
      if (cs2) obs_cs[2]++;
      if (int'(cs0) + int'(cs1) + int'(cs2) > 1) obs_multi++;
      if ((cs0 && a0 !== a[21:0]) || (cs1 && a1 !== a[21:0]) || (cs2 && a2 !== a[21:0])) obs_addr_err++;
      if (yvalid) begin
        obs_vcount++;
        if (obs_vcycle == 0) obs_vcycle = c;
        rd = 1'b0;
      end
      if (abort_at != 0 && c >= abort_at) rd = 1'b0;
      for (int b = 0; b < 3; b++)
        ok[b] = (b == sel) ? ((c == ok_at) || (stale && c == 1)) : 1'($urandom_range(0, 1));
      flush = (c == flush_at);
    end
    ok = 3'b000; flush = 1'b0; rd = 1'b0;
    obs_dout = ydout;
    obs_busy = busy;
  endtask

  task automatic pulse_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rd = 1'b0; flush = 1'b0; addr = 24'd0; ok = 3'b000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b0; m_tmo = 1'b0;
    checks++; if ({cs0, cs1, cs2} !== 3'b000) begin errors++; $display("FAIL reset_cs got %b exp 000", {cs0, cs1, cs2}); end
    checks++; if ({a0, a1, a2} !== 66'd0) begin errors++; $display("FAIL reset_addr got %h %h %h exp 0", a0, a1, a2); end
    checks++; if (ydout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", ydout); end
    checks++; if (yvalid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", yvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (tmo_err !== 1'b0) begin errors++; $display("FAIL reset_tmo got %b exp 0", tmo_err); end
  endtask

  task automatic test_miss();
    model_read(24'h000010, 3, 0, 0);
    run_read(24'h000010, 3, 1'b0, 0, 0);
    checks++; if (obs_cs[0] !== 3 || obs_cs[1] !== 0 || obs_cs[2] !== 0) begin errors++; $display("FAIL miss_cs got %0d/%0d/%0d exp 3/0/0", obs_cs[0], obs_cs[1], obs_cs[2]); end
    checks++; if (obs_addr_err !== 0) begin errors++; $display("FAIL miss_addr got %0d bad cycles exp 0", obs_addr_err); end
    checks++; if (obs_vcount !== 1 || obs_vcycle !== exp_vcycle) begin errors++; $display("FAIL miss_valid got %0d pulses at %0d exp 1 at %0d", obs_vcount, obs_vcycle, exp_vcycle); end
    checks++; if (obs_dout !== 8'hA5) begin errors++; $display("FAIL miss_dout got %h exp a5", obs_dout); end
    checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL miss_busy got %b exp 0", obs_busy); end
  endtask

  task automatic test_cache_hit();
    model_read(24'h000010, 3, 0, 0);
    run_read(24'h000010, 3, 1'b0, 0, 0);
    checks++; if (obs_cs[0] + obs_cs[1] + obs_cs[2] !== 0) begin errors++; $display("FAIL hit_cs got %0d cycles exp 0", obs_cs[0] + obs_cs[1] + obs_cs[2]); end
    checks++; if (obs_vcount !== 1 || obs_vcycle !== 1) begin errors++; $display("FAIL hit_valid got %0d pulses at %0d exp 1 at 1", obs_vcount, obs_vcycle); end
    checks++; if (obs_dout !== 8'hA5) begin errors++; $display("FAIL hit_dout got %h exp a5", obs_dout); end
    pulse_flush();
    model_read(24'h000010, 3, 0, 0);
    run_read(24'h000010, 3, 1'b0, 0, 0);
    checks++; if (obs_cs[0] !== exp_cs[0]) begin errors++; $display("FAIL flush_refetch_cs got %0d exp %0d", obs_cs[0], exp_cs[0]); end
    checks++; if (obs_dout !== exp_dout) begin errors++; $display("FAIL flush_refetch_dout got %h exp %h", obs_dout, exp_dout); end
  endtask

  task automatic test_banks();
    logic [23:0] list [2];
    int k;
    list[0] = 24'h4ABCDE; list[1] = 24'h812345;
    for (int i = 0; i < 2; i++) begin
      k = int'($urandom_range(2, 5));
      model_read(list[i], k, 0, 0);
      run_read(list[i], k, 1'b1, 0, 0);
      for (int b = 0; b < 3; b++) begin
        checks++; if (obs_cs[b] !== exp_cs[b]) begin errors++; $display("FAIL bank_cs addr %h bank %0d got %0d exp %0d", list[i], b, obs_cs[b], exp_cs[b]); end
      end
      checks++; if (obs_addr_err !== 0) begin errors++; $display("FAIL bank_addr addr %h got %0d bad cycles exp 0", list[i], obs_addr_err); end
      checks++; if (obs_dout !== exp_dout || obs_vcycle !== exp_vcycle) begin errors++; $display("FAIL bank_data addr %h got %h at %0d exp %h at %0d", list[i], obs_dout, obs_vcycle, exp_dout, exp_vcycle); end
    end
  endtask

  task automatic test_over_range();
    model_read(24'hC00000, 2, 0, 0);
    run_read(24'hC00000, 2, 1'b0, 0, 0);
    checks++; if (obs_cs[0] + obs_cs[1] + obs_cs[2] !== 0) begin errors++; $display("FAIL over_cs got %0d cycles exp 0", obs_cs[0] + obs_cs[1] + obs_cs[2]); end
    checks++; if (obs_vcount !== 1 || obs_vcycle !== 1) begin errors++; $display("FAIL over_valid got %0d pulses at %0d exp 1 at 1", obs_vcount, obs_vcycle); end
    checks++; if (obs_dout !== 8'h00) begin errors++; $display("FAIL over_dout got %h exp 00", obs_dout); end
  endtask

  task automatic test_timeout();
    // Put a non-zero byte on YMZ_DOUT first so the forced zero is visible
    model_read(24'h000123, 2, 0, 0);
    run_read(24'h000123, 2, 1'b0, 0, 0);
    model_read(24'h000300, 0, 0, 0);
    run_read(24'h000300, 0, 1'b0, 0, 0);
    checks++; if (obs_cs[0] !== TO) begin errors++; $display("FAIL tmo_cs got %0d exp %0d", obs_cs[0], TO); end
    checks++; if (obs_vcycle !== TO + 1 || obs_dout !== 8'h00) begin errors++; $display("FAIL tmo_result got %h at %0d exp 00 at %0d", obs_dout, obs_vcycle, TO + 1); end
    checks++; if (tmo_err !== 1'b1) begin errors++; $display("FAIL tmo_flag got %b exp 1", tmo_err); end
    model_read(24'h000304, 1, 0, 0);
    run_read(24'h000304, 1, 1'b1, 0, 0);
    checks++; if (obs_cs[0] !== exp_cs[0]) begin errors++; $display("FAIL stale_ok_cs got %0d exp %0d", obs_cs[0], exp_cs[0]); end
    model_read(24'h000308, 2, 0, 0);
    run_read(24'h000308, 2, 1'b1, 0, 0);
    checks++; if (obs_cs[0] !== exp_cs[0] || obs_dout !== exp_dout) begin errors++; $display("FAIL ok2_after_stale got %0d/%h exp %0d/%h", obs_cs[0], obs_dout, exp_cs[0], exp_dout); end
    checks++; if (tmo_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %b exp 1", tmo_err); end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk); rd = 1'b1; addr = 24'h400020; ok = 3'b000;
    repeat (3) @(negedge clk);
    checks++; if (cs1 !== 1'b1) begin errors++; $display("FAIL midwait_cs1 got %b exp 1", cs1); end
    rst = 1'b1; rd = 1'b0;
    @(negedge clk);
    checks++; if ({cs0, cs1, cs2} !== 3'b000 || yvalid !== 1'b0) begin errors++; $display("FAIL midwait_reset got cs %b valid %b exp 000 0", {cs0, cs1, cs2}, yvalid); end
    checks++; if (busy !== 1'b0 || tmo_err !== 1'b0) begin errors++; $display("FAIL midwait_state got busy %b tmo %b exp 0 0", busy, tmo_err); end
    rst = 1'b0;
    m_valid = 1'b0; m_tmo = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({cs0, cs1, cs2} !== 3'b000 || yvalid !== 1'b0) begin errors++; $display("FAIL midwait_after got cs %b valid %b exp 000 0", {cs0, cs1, cs2}, yvalid); end
  endtask

  task automatic test_abort();
    model_read(24'h000400, 3, 2, 0);
    run_read(24'h000400, 3, 1'b0, 2, 0);
    checks++; if (obs_vcount !== 0) begin errors++; $display("FAIL abort_valid got %0d pulses exp 0", obs_vcount); end
    checks++; if (obs_cs[0] !== exp_cs[0]) begin errors++; $display("FAIL abort_cs got %0d exp %0d", obs_cs[0], exp_cs[0]); end
    model_read(24'h000400, 3, 0, 0);
    run_read(24'h000400, 3, 1'b0, 0, 0);
    checks++; if (obs_cs[0] !== 0 || obs_vcycle !== 1) begin errors++; $display("FAIL abort_then_hit got cs %0d valid at %0d exp 0 at 1", obs_cs[0], obs_vcycle); end
    checks++; if (obs_dout !== exp_dout) begin errors++; $display("FAIL abort_then_hit_dout got %h exp %h", obs_dout, exp_dout); end
  endtask

  task automatic test_flush_fill();
    model_read(24'h000200, 4, 0, 4);
    run_read(24'h000200, 4, 1'b0, 0, 4);
    checks++; if (obs_vcount !== 1 || obs_dout !== exp_dout) begin errors++; $display("FAIL flushfill_return got %0d pulses %h exp 1 %h", obs_vcount, obs_dout, exp_dout); end
    model_read(24'h000200, 3, 0, 0);
    run_read(24'h000200, 3, 1'b0, 0, 0);
    checks++; if (obs_cs[0] !== exp_cs[0]) begin errors++; $display("FAIL flushfill_refetch got %0d exp %0d", obs_cs[0], exp_cs[0]); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] pattern;
    int cs_seen;
    pattern = 6'd0; cs_seen = 0;
    @(negedge clk); rd = 1'b1; addr = 24'h000200; ok = 3'b000;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      pattern[c] = yvalid;
      if (cs0 || cs1 || cs2) cs_seen++;
    end
    rd = 1'b0;
    @(negedge clk);
    checks++; if (pattern !== 6'b010101) begin errors++; $display("FAIL b2b_pattern got %b exp 010101", pattern); end
    checks++; if (cs_seen !== 0 || ydout !== m_data) begin errors++; $display("FAIL b2b_data got cs %0d dout %h exp 0 %h", cs_seen, ydout, m_data); end
  endtask

  task automatic test_random();
    logic [23:0] pool [8];
    logic [23:0] a;
    int ok_at, abort_at;
    bit stale;
    for (int i = 0; i < 8; i++) pool[i] = {2'($urandom_range(0, 3)), 22'($urandom)};
    for (int t = 0; t < 120; t++) begin
      a = pool[$urandom_range(0, 7)];
      ok_at = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      stale = 1'($urandom_range(0, 1));
      abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      if ($urandom_range(0, 15) == 0) pulse_flush();
      model_read(a, ok_at, abort_at, 0);
      run_read(a, ok_at, stale, abort_at, 0);
      for (int b = 0; b < 3; b++) begin
        checks++; if (obs_cs[b] !== exp_cs[b]) begin errors++; $display("FAIL rnd_cs t%0d addr %h bank %0d got %0d exp %0d", t, a, b, obs_cs[b], exp_cs[b]); end
      end
      checks++; if (obs_vcount !== exp_vcount || obs_vcycle !== exp_vcycle) begin errors++; $display("FAIL rnd_valid t%0d addr %h got %0d at %0d exp %0d at %0d", t, a, obs_vcount, obs_vcycle, exp_vcount, exp_vcycle); end
      checks++; if (obs_dout !== exp_dout) begin errors++; $display("FAIL rnd_dout t%0d addr %h got %h exp %h", t, a, obs_dout, exp_dout); end
      checks++; if (obs_addr_err !== 0 || obs_multi !== 0) begin errors++; $display("FAIL rnd_bus t%0d addr %h got addr_err %0d multi %0d exp 0 0", t, a, obs_addr_err, obs_multi); end
      checks++; if (tmo_err !== m_tmo || obs_busy !== 1'b0) begin errors++; $display("FAIL rnd_status t%0d got tmo %b busy %b exp %b 0", t, tmo_err, obs_busy, m_tmo); end
    end
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; flush = 1'b0; addr = 24'd0; ok = 3'b000;
    test_reset();
    test_miss();
    test_cache_hit();
    test_banks();
    test_over_range();
    test_timeout();
    test_reset_mid_wait();
    test_abort();
    test_flush_fill();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired: %0d checks, %0d errors so far", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
